// File: rtl/pipe_ctrl_gen.sv
// ============================================================================
// Module   : pipe_ctrl_gen
// Brief    : Parametrised stall/flush/redirect controller with a pending-jump
//            buffer and a drain-then-redirect trap sequencer.
//            Optional performance counters under `PIPE_CTRL_PERF_EN`.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_ctrl_gen #(
    parameter int NUM_STAGES = 6,
    parameter int ADDR_WIDTH = 32,
    parameter int JUMP_STAGE = 2,
    parameter int TRAP_STAGE = 3
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic [NUM_STAGES-1:0] stallreq_i,
    input  logic                  jump_en_i,
    input  logic [ADDR_WIDTH-1:0] jump_addr_i,
    input  logic                  trap_req_i,
    input  logic [ADDR_WIDTH-1:0] trap_pc_i,
    input  logic [ADDR_WIDTH-1:0] trap_vector_i,
    output logic [NUM_STAGES-1:0] stall_o,
    output logic [NUM_STAGES-1:0] flush_o,
    output logic                  new_pc_en_o,
    output logic [ADDR_WIDTH-1:0] new_pc_o,
    output logic [ADDR_WIDTH-1:0] epc_o,
    output logic                  trap_ack_o,
    output logic                  busy_o
`ifdef PIPE_CTRL_PERF_EN
    ,
    output logic [31:0]           perf_stall_cycles_o,
    output logic [31:0]           perf_flush_cnt_o
`endif
);

    function automatic logic [NUM_STAGES-1:0] range_mask(input int lo, input int hi);
        logic [NUM_STAGES-1:0] m;
        m = '0;
        for (int i = 0; i < NUM_STAGES; i++) begin
            if (i >= lo && i <= hi) m[i] = 1'b1;
        end
        return m;
    endfunction

    localparam logic [NUM_STAGES-1:0] c_jump_mask  = range_mask(1, JUMP_STAGE);
    localparam logic [NUM_STAGES-1:0] c_trap_mask  = range_mask(1, TRAP_STAGE);
    localparam logic [NUM_STAGES-1:0] c_older_mask = range_mask(TRAP_STAGE + 1, NUM_STAGES - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DRAIN    = 2'd1,
        REDIRECT = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic                    pend_vld_q, pend_vld_d;
    logic [ADDR_WIDTH-1:0]   pend_addr_q, pend_addr_d;
    logic [ADDR_WIDTH-1:0]   epc_q, epc_d;

    logic [NUM_STAGES-1:0]   w_stall_base;
    logic [NUM_STAGES-1:0]   w_stall;
    logic [NUM_STAGES-1:0]   w_flush;
    logic                    w_npc_en;
    logic [ADDR_WIDTH-1:0]   w_npc;
    logic                    w_ack;

    // A stall at stage k must also hold every younger register below it.
    assign w_stall_base[NUM_STAGES-1] = stallreq_i[NUM_STAGES-1];
    for (genvar j = 0; j < NUM_STAGES - 1; j++) begin : g_stall_chain
        assign w_stall_base[j] = w_stall_base[j+1] | stallreq_i[j];
    end

    always_comb begin
        state_d     = state_q;
        pend_vld_d  = pend_vld_q;
        pend_addr_d = pend_addr_q;
        epc_d       = epc_q;
        w_stall     = w_stall_base;
        w_flush     = '0;
        w_npc_en    = 1'b0;
        w_npc       = '0;
        w_ack       = 1'b0;

        case (state_q)
            IDLE: begin
                if (trap_req_i) begin
                    w_flush    = c_trap_mask;
                    epc_d      = trap_pc_i;
                    pend_vld_d = 1'b0;
                    state_d    = DRAIN;
                end else if (jump_en_i) begin
                    w_flush = c_jump_mask;
                    if (!w_stall_base[0]) begin
                        w_npc_en   = 1'b1;
                        w_npc      = jump_addr_i;
                        pend_vld_d = 1'b0;
                    end else begin
                        pend_vld_d  = 1'b1;
                        pend_addr_d = jump_addr_i;
                    end
                end else if (pend_vld_q && !w_stall_base[0]) begin
                    w_npc_en   = 1'b1;
                    w_npc      = pend_addr_q;
                    pend_vld_d = 1'b0;
                end
            end
            DRAIN: begin
                w_stall[0] = 1'b1;
                w_flush    = c_trap_mask;
                // Stages older than the trapping one must retire before redirect.
                if ((stallreq_i & c_older_mask) == '0) state_d = REDIRECT;
            end
            REDIRECT: begin
                w_npc_en = 1'b1;
                w_npc    = trap_vector_i;
                w_ack    = 1'b1;
                w_flush  = c_trap_mask;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase

        w_stall = w_stall & ~w_flush;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= IDLE;
            pend_vld_q  <= 1'b0;
            pend_addr_q <= '0;
            epc_q       <= '0;
        end else begin
            state_q     <= state_d;
            pend_vld_q  <= pend_vld_d;
            pend_addr_q <= pend_addr_d;
            epc_q       <= epc_d;
        end
    end

    // Combinational outputs are held at zero while reset is asserted.
    assign stall_o     = rst_n_i ? w_stall  : '0;
    assign flush_o     = rst_n_i ? w_flush  : '0;
    assign new_pc_en_o = rst_n_i & w_npc_en;
    assign new_pc_o    = rst_n_i ? w_npc    : '0;
    assign trap_ack_o  = rst_n_i & w_ack;
    assign epc_o       = epc_q;
    assign busy_o      = (state_q != IDLE);

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] perf_stall_q, perf_stall_d;
    logic [31:0] perf_flush_q, perf_flush_d;

    always_comb begin
        perf_stall_d = perf_stall_q + {31'd0, stall_o[0]};
        perf_flush_d = perf_flush_q + {31'd0, new_pc_en_o};
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            perf_stall_q <= '0;
            perf_flush_q <= '0;
        end else begin
            perf_stall_q <= perf_stall_d;
            perf_flush_q <= perf_flush_d;
        end
    end

    assign perf_stall_cycles_o = perf_stall_q;
    assign perf_flush_cnt_o    = perf_flush_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipe_ctrl_gen.sv
// ============================================================================
// Module   : tb_pipe_ctrl_gen
// Brief    : Directed self-checking bench for pipe_ctrl_gen (default params).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipe_ctrl_gen;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [5:0]  stallreq = '0;
    logic        jump_en = 1'b0;
    logic [31:0] jump_addr = '0;
    logic        trap_req = 1'b0;
    logic [31:0] trap_pc = '0;
    logic [31:0] trap_vec = '0;
    logic [5:0]  stall;
    logic [5:0]  flush;
    logic        npc_en;
    logic [31:0] npc;
    logic [31:0] epc;
    logic        ack;
    logic        busy;
`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] perf_stall;
    logic [31:0] perf_flush;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    pipe_ctrl_gen dut (
        .clk_i        (clk),
        .rst_n_i      (rst_n),
        .stallreq_i   (stallreq),
        .jump_en_i    (jump_en),
        .jump_addr_i  (jump_addr),
        .trap_req_i   (trap_req),
        .trap_pc_i    (trap_pc),
        .trap_vector_i(trap_vec),
        .stall_o      (stall),
        .flush_o      (flush),
        .new_pc_en_o  (npc_en),
        .new_pc_o     (npc),
        .epc_o        (epc),
        .trap_ack_o   (ack),
        .busy_o       (busy)
`ifdef PIPE_CTRL_PERF_EN
        ,
        .perf_stall_cycles_o(perf_stall),
        .perf_flush_cnt_o   (perf_flush)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive the next cycle's inputs just after the falling edge.
    task automatic drive(input logic [5:0] sr, input logic je, input logic [31:0] ja,
                         input logic tr);
        @(negedge clk);
        stallreq  = sr;
        jump_en   = je;
        jump_addr = ja;
        trap_req  = tr;
        #1;
    endtask

    initial begin
        #2 rst_n = 1'b0;
        stallreq = 6'b001000;
        @(negedge clk); #1;
        chk("rst_stall", stall, 6'b0);
        chk("rst_flush", flush, 6'b0);
        chk("rst_npc_en", npc_en, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_epc", epc, 32'h0);

        @(negedge clk); rst_n = 1'b1; #1;
        chk("stall_bit3", stall, 6'b001111);
        drive(6'b000100, 1'b0, 32'h0, 1'b0);
        chk("stall_bit2", stall, 6'b000111);
        drive(6'b100000, 1'b0, 32'h0, 1'b0);
        chk("stall_bit5", stall, 6'b111111);

        // Unstalled jump
        drive(6'b000000, 1'b1, 32'h100, 1'b0);
        chk("jmp_en", npc_en, 1'b1);
        chk("jmp_pc", npc, 32'h100);
        chk("jmp_flush", flush, 6'b000110);
        drive(6'b000000, 1'b0, 32'h0, 1'b0);
        chk("jmp_done_en", npc_en, 1'b0);
        chk("jmp_done_pc", npc, 32'h0);

        // Jump while stalled, released two cycles later
        drive(6'b000100, 1'b1, 32'h200, 1'b0);
        chk("sjmp_flush", flush, 6'b000110);
        chk("sjmp_stall", stall, 6'b000001);
        chk("sjmp_en1", npc_en, 1'b0);
        drive(6'b000100, 1'b0, 32'h0, 1'b0);
        chk("sjmp_en2", npc_en, 1'b0);
        chk("sjmp_stall2", stall, 6'b000111);
        drive(6'b000100, 1'b0, 32'h0, 1'b0);
        chk("sjmp_en3", npc_en, 1'b0);
        drive(6'b000000, 1'b0, 32'h0, 1'b0);
        chk("sjmp_rel_en", npc_en, 1'b1);
        chk("sjmp_rel_pc", npc, 32'h200);
        chk("sjmp_rel_flush", flush, 6'b0);
        drive(6'b000000, 1'b0, 32'h0, 1'b0);
        chk("sjmp_once", npc_en, 1'b0);

        // Newest buffered jump wins
        drive(6'b000001, 1'b1, 32'h400, 1'b0);
        drive(6'b000001, 1'b1, 32'h500, 1'b0);
        chk("ovw_en", npc_en, 1'b0);
        drive(6'b000000, 1'b0, 32'h0, 1'b0);
        chk("ovw_pc", npc, 32'h500);
        chk("ovw_en2", npc_en, 1'b1);

        // Trap with an older stage still busy
        trap_pc  = 32'h80;
        trap_vec = 32'h1000;
        drive(6'b010000, 1'b0, 32'h0, 1'b1);
        chk("trap0_flush", flush, 6'b001110);
        chk("trap0_stall", stall, 6'b010001);
        chk("trap0_busy", busy, 1'b0);
        drive(6'b010000, 1'b0, 32'h0, 1'b0);
        chk("drain1_busy", busy, 1'b1);
        chk("drain1_epc", epc, 32'h80);
        chk("drain1_stall", stall, 6'b010001);
        chk("drain1_en", npc_en, 1'b0);
        drive(6'b000000, 1'b0, 32'h0, 1'b0);
        chk("drain2_stall", stall, 6'b000001);
        chk("drain2_en", npc_en, 1'b0);
        drive(6'b000000, 1'b0, 32'h0, 1'b0);
        chk("redir_en", npc_en, 1'b1);
        chk("redir_pc", npc, 32'h1000);
        chk("redir_ack", ack, 1'b1);
        chk("redir_flush", flush, 6'b001110);
        drive(6'b000000, 1'b0, 32'h0, 1'b0);
        chk("post_busy", busy, 1'b0);
        chk("post_ack", ack, 1'b0);

        // Trap beats a same-cycle jump; jump during DRAIN is ignored
        trap_pc = 32'h84;
        drive(6'b000000, 1'b1, 32'h300, 1'b1);
        chk("tbj_en", npc_en, 1'b0);
        chk("tbj_flush", flush, 6'b001110);
        drive(6'b000000, 1'b1, 32'h304, 1'b0);
        chk("tbj_drain_en", npc_en, 1'b0);
        chk("tbj_epc", epc, 32'h84);
        drive(6'b000000, 1'b0, 32'h0, 1'b0);
        chk("tbj_redir_pc", npc, 32'h1000);
        chk("tbj_redir_ack", ack, 1'b1);
        drive(6'b000000, 1'b0, 32'h0, 1'b0);
        chk("tbj_no_jump", npc_en, 1'b0);
        chk("tbj_idle", busy, 1'b0);

        // Reset discards a pending jump and clears epc
        drive(6'b000001, 1'b1, 32'h600, 1'b0);
        drive(6'b000001, 1'b0, 32'h0, 1'b0);
        rst_n = 1'b0; #1;
        chk("arst_epc", epc, 32'h0);
        drive(6'b000000, 1'b0, 32'h0, 1'b0);
        rst_n = 1'b1; #1;
        chk("arst_no_pend", npc_en, 1'b0);
        drive(6'b000000, 1'b0, 32'h0, 1'b0);
        chk("arst_no_pend2", npc_en, 1'b0);

`ifdef PIPE_CTRL_PERF_EN
        drive(6'b000000, 1'b0, 32'h0, 1'b0);
        rst_n = 1'b0; #1;
        chk("perf_rst_s", perf_stall, 32'd0);
        chk("perf_rst_f", perf_flush, 32'd0);
        @(negedge clk); rst_n = 1'b1; stallreq = 6'b000001;
        repeat (5) @(negedge clk);
        stallreq = 6'b000000; jump_en = 1'b1; jump_addr = 32'h10; #1;
        chk("perf_stall5", perf_stall, 32'd5);
        drive(6'b000000, 1'b1, 32'h20, 1'b0);
        drive(6'b000001, 1'b0, 32'h0, 1'b0);
        chk("perf_flush2", perf_flush, 32'd2);
        chk("perf_stall5b", perf_stall, 32'd5);
        @(posedge clk); #2;
        rst_n = 1'b0; #1;
        chk("perf_arst_s", perf_stall, 32'd0);
        chk("perf_arst_f", perf_flush, 32'd0);
        @(negedge clk); rst_n = 1'b1; stallreq = 6'b000000;
`endif

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
